// File: rtl/load_store_unit.sv
// Load/store engine between the MEM stage and a word-wide data memory.
// Byte/half/word loads and stores, big-endian lanes, sub-word stores via
// read-modify-write, alignment checking and a Ready/Req handshake.
//
// state  | meaning
// IDLE   | Ready high, waiting for a request
// LOAD   | reading the addressed word, result registered at end of cycle
// STORE  | writing a full word
// RMW_RD | reading the word that a byte/half store will patch
// RMW_WR | writing the patched word back
// FAULT  | request rejected, Error high for this one cycle
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Req,
  input  logic [3:0]               Op,
  input  logic [31:0]              Addr,
  input  logic [DATA_WIDTH-1:0]    StoreData,
  output logic                     Ready,
  output logic [DATA_WIDTH-1:0]    LoadData,
  output logic                     LoadValid,
  output logic                     Error,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  output logic                     MemWrite,
  input  logic [DATA_WIDTH-1:0]    MemData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t                   state, state_nx;
  logic [2:0]               op_q;          // {unsigned, size}
  logic [ADDRESS_WIDTH+1:0] addr_q;        // byte address, upper bits dropped so it wraps
  logic [DATA_WIDTH-1:0]    data_q;        // store data, later the merged RMW word
  logic [DATA_WIDTH-1:0]    load_data_q;
  logic                     load_valid_q;

  logic                     req_fault;
  logic [4:0]               byte_shift;
  logic [4:0]               half_shift;
  logic [7:0]               lane_byte;
  logic [15:0]              lane_half;
  logic [DATA_WIDTH-1:0]    load_ext;
  logic [DATA_WIDTH-1:0]    merged_word;
  logic                     unused_addr_hi;

  // Address bits above the memory size are deliberately ignored.
  assign unused_addr_hi = ^Addr[31:ADDRESS_WIDTH+2];

  // Alignment / size check on the incoming request.
  always_comb begin
    req_fault = 1'b0;
    case (Op[1:0])
      SZ_HALF: req_fault = Addr[0];
      SZ_WORD: req_fault = |Addr[1:0];
      SZ_RSVD: req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
  end

  // Big-endian lanes: byte k sits at bits [31-8k -: 8], so shift right by 8*(3-k).
  assign byte_shift = {~addr_q[1:0], 3'b000};
  assign half_shift = {~addr_q[1], 4'b0000};
  assign lane_byte  = 8'(MemData >> byte_shift);
  assign lane_half  = 16'(MemData >> half_shift);

  // Sign/zero extension of the selected lane.
  always_comb begin
    load_ext = MemData;
    case (op_q[1:0])
      SZ_BYTE: load_ext = op_q[2] ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = op_q[2] ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_ext = MemData;
    endcase
  end

  // Patch the new byte/half into the word just read.
  always_comb begin
    merged_word = MemData;
    if (op_q[1:0] == SZ_BYTE) begin
      merged_word = (MemData & ~(32'h0000_00FF << byte_shift)) |
                    ({24'h0, data_q[7:0]} << byte_shift);
    end else if (op_q[1:0] == SZ_HALF) begin
      merged_word = (MemData & ~(32'h0000_FFFF << half_shift)) |
                    ({16'h0, data_q[15:0]} << half_shift);
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and state-decoded handshake/memory strobes.
  always_comb begin
    state_nx = state;
    Ready    = 1'b0;
    MemWrite = 1'b0;
    Error    = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Req) begin
          if (req_fault)             state_nx = FAULT;
          else if (!Op[3])           state_nx = LOAD;
          else if (Op[1:0] == SZ_WORD) state_nx = STORE;
          else                       state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = IDLE;
      STORE: begin
        MemWrite = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD:  state_nx = RMW_WR;
      RMW_WR: begin
        MemWrite = 1'b1;
        state_nx = IDLE;
      end
      FAULT: begin
        Error    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, RMW merge and load result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            op_q   <= Op[2:0];
            addr_q <= Addr[ADDRESS_WIDTH+1:0];
            data_q <= StoreData;
          end
        end
        LOAD: begin
          load_data_q  <= load_ext;
          load_valid_q <= 1'b1;
        end
        RMW_RD:  data_q <= merged_word;
        default: ;
      endcase
    end
  end

  assign MemAddress   = addr_q[ADDRESS_WIDTH+1:2];
  assign MemWriteData = data_q;
  assign LoadData     = load_data_q;
  assign LoadValid    = load_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic compared against a byte-addressed big-endian memory model.
module tb_load_store_unit;
  localparam int AW = 16;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Req;
  logic [3:0]    Op;
  logic [31:0]   Addr;
  logic [31:0]   StoreData;
  logic          Ready;
  logic [31:0]   LoadData;
  logic          LoadValid;
  logic          Error;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemWriteData;
  logic          MemWrite;
  logic [31:0]   MemData;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .Ready(Ready), .LoadData(LoadData),
    .LoadValid(LoadValid), .Error(Error), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemData(MemData)
  );

  // Data memory: combinational read, posedge write, preloaded from init_words.
  logic [31:0] dmem [0:(1<<AW)-1];
  logic [31:0] init_words [0:63];
  logic        preload;
  assign MemData = dmem[MemAddress];
  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_words[i];
    end else if (MemWrite) begin
      dmem[MemAddress] <= MemWriteData;
    end
  end

  // Reference: flat byte memory, byte address modulo 2^18, big-endian words.
  logic [7:0]  ref_mem [int];
  logic [31:0] last_load;

  function automatic int ba_of(input logic [31:0] a);
    return int'(a[17:0]);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = ba_of(a) & ~3;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic logic model_fault(input logic [3:0] op, input logic [31:0] a);
    if (op[1:0] == 2'b11) return 1'b1;
    if (op[1:0] == 2'b01) return a[0];
    if (op[1:0] == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
    int b;
    int v;
    b = ba_of(a);
    if (op[1:0] == 2'b00) begin
      v = int'(ref_mem[b]);
      if (!op[2] && v >= 128) v = v - 256;
      return 32'(v);
    end else if (op[1:0] == 2'b01) begin
      v = int'(ref_mem[b]) * 256 + int'(ref_mem[b+1]);
      if (!op[2] && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic model_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd);
    int b;
    b = ba_of(a);
    if (op[1:0] == 2'b00) begin
      ref_mem[b] = sd[7:0];
    end else if (op[1:0] == 2'b01) begin
      ref_mem[b]   = sd[15:8];
      ref_mem[b+1] = sd[7:0];
    end else begin
      ref_mem[b]   = sd[31:24];
      ref_mem[b+1] = sd[23:16];
      ref_mem[b+2] = sd[15:8];
      ref_mem[b+3] = sd[7:0];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from an idle unit, followed until Ready returns.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd);
    logic        f;
    logic        is_ld;
    int          exp_busy;
    int          busy;
    int          writes;
    int          errs;
    int          lvs;
    logic [31:0] exp_ld;
    f        = model_fault(op, a);
    is_ld    = !f && !op[3];
    exp_busy = (!f && op[3] && op[1:0] != 2'b10) ? 2 : 1;
    exp_ld   = model_load(op, a);
    busy = 0; writes = 0; errs = 0; lvs = 0;
    @(negedge Clk);
    check("ready_before", 32'(Ready), 32'd1);
    Req = 1'b1; Op = op; Addr = a; StoreData = sd;
    @(posedge Clk);
    #1 Req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (Ready) break;
      busy++;
      writes += int'(MemWrite);
      errs   += int'(Error);
      lvs    += int'(LoadValid);
      if (busy == 1) check("mem_address", {16'h0, MemAddress}, {16'h0, a[17:2]});
    end
    check("busy_cycles", 32'(busy), 32'(exp_busy));
    check("write_cycles", 32'(writes), (!f && op[3]) ? 32'd1 : 32'd0);
    check("error_cycles", 32'(errs), f ? 32'd1 : 32'd0);
    check("lv_while_busy", 32'(lvs), 32'd0);
    check("load_valid", 32'(LoadValid), 32'(is_ld));
    check("error_idle", 32'(Error), 32'd0);
    if (is_ld) last_load = exp_ld;
    check("load_data", LoadData, last_load);
    if (!f && op[3]) model_store(op, a, sd);
    check("mem_word", dmem[a[17:2]], ref_word(a));
  endtask

  logic [3:0]  b_op [3];
  logic [31:0] b_ad [3];
  logic [31:0] b_sd [3];
  logic [31:0] b_ld [3];
  int          b_gap [3];
  int          issued;
  int          cur_gap;
  logic        done;
  logic [1:0]  r_sz;
  logic [3:0]  r_op;
  logic [31:0] r_a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; Req = 1'b0; Op = '0; Addr = '0; StoreData = '0;
    preload = 1'b1; last_load = '0;
    for (int b = 0; b < 256; b++) ref_mem[b] = 8'($urandom);
    for (int w = 0; w < 64; w++)
      init_words[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    preload = 1'b0;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_load_valid", 32'(LoadValid), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_mem_write", 32'(MemWrite), 32'd0);
    check("rst_load_data", LoadData, 32'd0);
    check("rst_mem_address", {16'h0, MemAddress}, 32'd0);
    check("rst_write_data", MemWriteData, 32'd0);
    Rst_n = 1'b1;

    // Reset during RMW_RD aborts the store.
    @(negedge Clk);
    Req = 1'b1; Op = 4'b1000; Addr = 32'h30; StoreData = 32'hEE;
    @(posedge Clk);
    #1 Req = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("abort_mem_write", 32'(MemWrite), 32'd0);
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_load_valid", 32'(LoadValid), 32'd0);
    check("abort_error", 32'(Error), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    last_load = '0;
    @(negedge Clk);
    @(negedge Clk);
    check("abort_mem_word", dmem[12], ref_word(32'h30));
    check("abort_no_pulse", {30'h0, LoadValid, Error}, 32'd0);

    // Word store then load back.
    run_op(4'b1010, 32'h10, 32'h1234_5678);
    run_op(4'b0010, 32'h10, 32'h0);
    check("lw_const", LoadData, 32'h1234_5678);

    // Sub-word loads with extension.
    run_op(4'b1010, 32'h20, 32'hAABB_CCDD);
    run_op(4'b0000, 32'h20, 32'h0);
    check("lb_const", LoadData, 32'hFFFF_FFAA);
    run_op(4'b0100, 32'h23, 32'h0);
    check("lbu_const", LoadData, 32'h0000_00DD);
    run_op(4'b0001, 32'h22, 32'h0);
    check("lh_const", LoadData, 32'hFFFF_CCDD);
    run_op(4'b0101, 32'h20, 32'h0);
    check("lhu_const", LoadData, 32'h0000_AABB);

    // Sub-word stores via read-modify-write.
    run_op(4'b1000, 32'h21, 32'h0000_0011);
    check("sb_const", dmem[8], 32'hAA11_CCDD);
    run_op(4'b1001, 32'h22, 32'h0000_2233);
    check("sh_const", dmem[8], 32'hAA11_2233);

    // Faults: misaligned word, misaligned half, reserved size (load and store).
    run_op(4'b0010, 32'h22, 32'h0);
    run_op(4'b1001, 32'h21, 32'hFFFF);
    run_op(4'b0011, 32'h20, 32'h0);
    run_op(4'b1011, 32'h24, 32'h5555_5555);

    // Address wraps modulo memory size.
    run_op(4'b1010, 32'h8004_0040, 32'hCAFE_F00D);
    run_op(4'b0010, 32'h40, 32'h0);
    check("wrap_const", LoadData, 32'hCAFE_F00D);

    // Back-to-back with Req held high: LW, SB, LW.
    b_op[0] = 4'b0010; b_ad[0] = 32'h44; b_sd[0] = 32'h0;
    b_op[1] = 4'b1000; b_ad[1] = 32'h45; b_sd[1] = 32'h5A;
    b_op[2] = 4'b0010; b_ad[2] = 32'h44; b_sd[2] = 32'h0;
    issued = 0; cur_gap = 0; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge Clk);
      if (Ready) begin
        if (issued > 0) begin
          b_gap[issued-1] = cur_gap;
          if (!b_op[issued-1][3]) begin
            check("b2b_load_valid", 32'(LoadValid), 32'd1);
            check("b2b_load_data", LoadData, b_ld[issued-1]);
          end
        end
        if (issued == 3) begin
          done = 1'b1;
        end else begin
          Req = 1'b1; Op = b_op[issued]; Addr = b_ad[issued]; StoreData = b_sd[issued];
          b_ld[issued] = model_load(b_op[issued], b_ad[issued]);
          if (b_op[issued][3]) model_store(b_op[issued], b_ad[issued], b_sd[issued]);
          issued++;
          cur_gap = 0;
        end
      end else begin
        cur_gap++;
      end
    end
    Req = 1'b0;
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_gap0", 32'(b_gap[0]), 32'd1);
    check("b2b_gap1", 32'(b_gap[1]), 32'd2);
    check("b2b_gap2", 32'(b_gap[2]), 32'd1);
    check("b2b_mem_word", dmem[17], ref_word(32'h44));
    last_load = b_ld[2];

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_op = {1'($urandom), 1'($urandom), r_sz};
      r_a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'b01) r_a[0] = 1'b0;
        else if (r_sz != 2'b00) r_a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 4) == 0) r_a = r_a | (32'($urandom) << 18);
      run_op(r_op, r_a, 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
